// File: rtl/sync_gate_pkg.sv
// Shared definitions for the Sync/Gate/Done timing blocks: FSM states,
// counter operations, error codes and default field widths.
package sync_gate_pkg;

   localparam int DEF_SHORT_W = 8;
   localparam int DEF_LONG_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_GDEL = 3'd2,
      ST_GATE = 3'd3,
      ST_LEN  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CNT_HOLD  = 2'd0,
      CNT_CLEAR = 2'd1,
      CNT_LOAD1 = 2'd2,
      CNT_INC   = 2'd3
   } cnt_op_t;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_OVERLAP   = 2'd1;
   localparam logic [1:0] ERR_SHORT_SAT = 2'd2;
   localparam logic [1:0] ERR_LONG_SAT  = 2'd3;

endpackage

// File: rtl/sync_gate_meter_phase_counter.sv
// Loadable phase counter; sat warns that the next increment would pass limit,
// so one instance serves both the short and the long measurement fields.
module phase_counter
   import sync_gate_pkg::*;
#(
   parameter int W = DEF_LONG_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  cnt_op_t      op,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         case (op)
            CNT_CLEAR: cnt_q <= '0;
            CNT_LOAD1: cnt_q <= {{(W-1){1'b0}}, 1'b1};
            CNT_INC:   cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
            default:   cnt_q <= cnt_q;
         endcase
      end
   end

   assign cnt = cnt_q;
   assign sat = (cnt_q >= limit);

endmodule

// File: rtl/sync_gate_meter.sv
// Receive-side meter for the Sync/Gate/Done frame: recovers sync width, gate
// delay, gate width and trailing length, and flags overlap/saturation.
module sync_gate_meter
   import sync_gate_pkg::*;
#(
   parameter int SHORT_W = DEF_SHORT_W,
   parameter int LONG_W  = DEF_LONG_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               sync,
   input  logic               gate,
   input  logic               done,
   output logic [SHORT_W-1:0] tsync,
   output logic [SHORT_W-1:0] tgdel,
   output logic [LONG_W-1:0]  tgate,
   output logic [LONG_W-1:0]  tlen,
   output logic               valid,
   output logic               err,
   output logic [1:0]         err_code,
   output state_t             dbg_state
);

   localparam logic [LONG_W-1:0] SHORT_LIMIT = {{(LONG_W-SHORT_W){1'b0}}, {SHORT_W{1'b1}}};
   localparam logic [LONG_W-1:0] LONG_LIMIT  = {LONG_W{1'b1}};

   state_t              state_q, state_d;
   cnt_op_t             cnt_op;
   logic [LONG_W-1:0]   cnt, limit;
   logic                sat;

   logic [SHORT_W-1:0]  stg_tsync_q, stg_tgdel_q;
   logic [LONG_W-1:0]   stg_tgate_q;
   logic [SHORT_W-1:0]  tsync_q, tgdel_q;
   logic [LONG_W-1:0]   tgate_q, tlen_q;
   logic                valid_q, err_q;
   logic [1:0]          err_code_q;

   logic                cap_tsync, cap_tgdel, cap_tgdel_zero, cap_tgate, frame_end_d;
   logic [1:0]          fault_d;

   phase_counter #(.W(LONG_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (cnt_op),
      .limit (limit),
      .cnt   (cnt),
      .sat   (sat)
   );

   assign limit = (state_q == ST_GATE || state_q == ST_LEN) ? LONG_LIMIT : SHORT_LIMIT;

   always_comb begin
      state_d        = state_q;
      cnt_op         = CNT_HOLD;
      cap_tsync      = 1'b0;
      cap_tgdel      = 1'b0;
      cap_tgdel_zero = 1'b0;
      cap_tgate      = 1'b0;
      frame_end_d    = 1'b0;
      fault_d        = ERR_NONE;
      if (!ena) begin
         state_d = ST_IDLE;
         cnt_op  = CNT_CLEAR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sync && !gate) begin
                  state_d = ST_SYNC;
                  cnt_op  = CNT_LOAD1;
               end
            end
            ST_SYNC: begin
               case ({sync, gate})
                  2'b10: begin
                     if (sat) fault_d = ERR_SHORT_SAT;
                     else     cnt_op  = CNT_INC;
                  end
                  2'b00: begin
                     cap_tsync = 1'b1;
                     state_d   = ST_GDEL;
                     cnt_op    = CNT_LOAD1;
                  end
                  2'b01: begin
                     cap_tsync      = 1'b1;
                     cap_tgdel_zero = 1'b1;
                     state_d        = ST_GATE;
                     cnt_op         = CNT_LOAD1;
                  end
                  default: fault_d = ERR_OVERLAP;
               endcase
            end
            ST_GDEL: begin
               if (sync) begin
                  fault_d = ERR_OVERLAP;
               end else if (gate) begin
                  cap_tgdel = 1'b1;
                  state_d   = ST_GATE;
                  cnt_op    = CNT_LOAD1;
               end else if (sat) begin
                  fault_d = ERR_SHORT_SAT;
               end else begin
                  cnt_op = CNT_INC;
               end
            end
            ST_GATE: begin
               if (sync) begin
                  fault_d = ERR_OVERLAP;
               end else if (!gate) begin
                  cap_tgate = 1'b1;
                  state_d   = ST_LEN;
                  cnt_op    = CNT_LOAD1;
               end else if (sat) begin
                  fault_d = ERR_LONG_SAT;
               end else begin
                  cnt_op = CNT_INC;
               end
            end
            ST_LEN: begin
               // done outranks both a new Sync and a stray Gate
               if (done) begin
                  frame_end_d = 1'b1;
                  state_d     = ST_IDLE;
                  cnt_op      = CNT_CLEAR;
               end else if (gate) begin
                  fault_d = ERR_OVERLAP;
               end else if (sync) begin
                  frame_end_d = 1'b1;
                  state_d     = ST_SYNC;
                  cnt_op      = CNT_LOAD1;
               end else if (sat) begin
                  fault_d = ERR_LONG_SAT;
               end else begin
                  cnt_op = CNT_INC;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_op  = CNT_CLEAR;
            end
         endcase
         if (fault_d != ERR_NONE) begin
            state_d = ST_IDLE;
            cnt_op  = CNT_CLEAR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         stg_tsync_q <= '0;
         stg_tgdel_q <= '0;
         stg_tgate_q <= '0;
         tsync_q     <= '0;
         tgdel_q     <= '0;
         tgate_q     <= '0;
         tlen_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         valid_q <= frame_end_d;
         err_q   <= (fault_d != ERR_NONE);
         if (fault_d != ERR_NONE) err_code_q <= fault_d;
         if (!ena) begin
            stg_tsync_q <= '0;
            stg_tgdel_q <= '0;
            stg_tgate_q <= '0;
         end else begin
            if (cap_tsync)      stg_tsync_q <= cnt[SHORT_W-1:0];
            if (cap_tgdel_zero) stg_tgdel_q <= '0;
            if (cap_tgdel)      stg_tgdel_q <= cnt[SHORT_W-1:0];
            if (cap_tgate)      stg_tgate_q <= cnt;
         end
         // Outputs move only as a complete frame
         if (frame_end_d) begin
            tsync_q <= stg_tsync_q;
            tgdel_q <= stg_tgdel_q;
            tgate_q <= stg_tgate_q;
            tlen_q  <= cnt;
         end
      end
   end

   assign tsync     = tsync_q;
   assign tgdel     = tgdel_q;
   assign tgate     = tgate_q;
   assign tlen      = tlen_q;
   assign valid     = valid_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_gate_meter.sv
// Directed bench for sync_gate_meter with a queue-based scoreboard: stimulus
// pushes the expected report, a negedge monitor pops on every valid/err.
module tb_sync_gate_meter;
  import sync_gate_pkg::*;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [7:0]  ts;
    logic [7:0]  tgd;
    logic [15:0] tg;
    logic [15:0] tl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        sync = 1'b0;
  logic        gate = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  tsync, tgdel;
  logic [15:0] tgate, tlen;
  logic        valid, err;
  logic [1:0]  err_code;
  state_t      dbg_state;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;

  sync_gate_meter #(.SHORT_W(8), .LONG_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sync      (sync),
    .gate      (gate),
    .done      (done),
    .tsync     (tsync),
    .tgdel     (tgdel),
    .tgate     (tgate),
    .tlen      (tlen),
    .valid     (valid),
    .err       (err),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic g, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      sync = s;
      gate = g;
      done = d;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int ts, input int tgd, input int tg, input int tl);
    drive(1'b1, 1'b0, 1'b0, ts);
    if (tgd > 0) drive(1'b0, 1'b0, 1'b0, tgd);
    drive(1'b0, 1'b1, 1'b0, tg);
    drive(1'b0, 1'b0, 1'b0, tl);
  endtask

  task automatic push_frame(input int ts, input int tgd, input int tg, input int tl);
    cur.ts  = 8'(ts);
    cur.tgd = 8'(tgd);
    cur.tg  = 16'(tg);
    cur.tl  = 16'(tl);
    cur.is_err = 1'b0;
    cur.code   = 2'd0;
    exp_q.push_back(cur);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e = cur;
    e.is_err = 1'b1;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tsync"}, tsync, 0);
    chk({tag, "_tgdel"}, tgdel, 0);
    chk({tag, "_tgate"}, tgate, 0);
    chk({tag, "_tlen"}, tlen, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (valid && err) chk("valid_err_exclusive", 1, 0);
    if (valid || err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_report", {valid, err}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("report_is_err", err, e.is_err);
        chk("report_tsync", tsync, e.ts);
        chk("report_tgdel", tgdel, e.tgd);
        chk("report_tgate", tgate, e.tg);
        chk("report_tlen", tlen, e.tl);
        if (e.is_err) chk("report_err_code", err_code, e.code);
      end
    end
  end

  initial begin
    cur = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset_in");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2);
    chk_zero_outputs("after_reset");

    // basic frame ended by done
    frame(3, 2, 5, 4);
    push_frame(3, 2, 5, 4);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 2);
    chk("frame1_back_to_idle", dbg_state, ST_IDLE);

    // minimum frame with zero gate delay
    frame(1, 0, 1, 1);
    push_frame(1, 0, 1, 1);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 2);

    // back-to-back frames: second frame's first sync sample ends the first
    frame(3, 2, 5, 4);
    push_frame(3, 2, 5, 4);
    frame(7, 1, 10, 20);
    push_frame(7, 1, 10, 20);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 2);

    // overlap while Sync high, then a clean frame
    drive(1'b1, 1'b0, 1'b0, 2);
    push_err(ERR_OVERLAP);
    drive(1'b1, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 2);
    chk("overlap_code_held", err_code, ERR_OVERLAP);
    frame(2, 3, 4, 5);
    push_frame(2, 3, 4, 5);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 2);

    // Sync high for 300 cycles: 256th sample saturates the short field
    drive(1'b1, 1'b0, 1'b0, 255);
    push_err(ERR_SHORT_SAT);
    drive(1'b1, 1'b0, 1'b0, 45);
    ena = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1);
    ena = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2);
    chk("sat_code_held", err_code, ERR_SHORT_SAT);
    chk("sat_tsync_kept", tsync, 2);

    // ena dropped in GATE aborts silently
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 3);
    ena = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1);
    ena = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3);
    chk("ena_abort_idle", dbg_state, ST_IDLE);
    chk("ena_abort_tgate_kept", tgate, 4);
    frame(4, 4, 4, 4);
    push_frame(4, 4, 4, 4);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 2);

    // asynchronous reset mid-LEN
    frame(2, 2, 2, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_len_reset");
    cur = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2);
    chk_zero_outputs("post_reset");
    frame(5, 6, 7, 8);
    push_frame(5, 6, 7, 8);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 4);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_gate_meter.md
# sync_gate_meter

Measures the Sync/Gate/Done frame produced by the gate-timing generator and recovers its four programmed intervals: sync width, gate delay, gate width and trailing length. The block sits on the receive side of the generator's output pins, for loop-back checking and for board-level timing readback. It reports each completed frame as a one-cycle `valid` pulse with registered measurements, and flags protocol violations on `err`.

## Interface
- `SHORT_W`, default 8: width of the `tsync` and `tgdel` measurements. Matches the generator's `Tsync`/`Tgdel`.
- `LONG_W`, default 16: width of the `tgate` and `tlen` measurements and of the internal counter.
- `clk` input 1: single clock. All inputs are sampled on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: measurement enable. Same meaning as the generator's `ena`.
- `sync` input 1: generator Sync, synchronous to `clk`.
- `gate` input 1: generator Gate, synchronous to `clk`.
- `done` input 1: generator Done. Terminates the trailing phase.
- `tsync` output SHORT_W: measured Sync-high cycles.
- `tgdel` output SHORT_W: measured cycles with both signals low between Sync and Gate.
- `tgate` output LONG_W: measured Gate-high cycles.
- `tlen` output LONG_W: measured trailing cycles, from Gate fall to the next Sync rise or to `done`.
- `valid` output 1: one-cycle pulse; the four measurements above are updated in the same cycle.
- `err` output 1: one-cycle pulse on a protocol violation or a saturation.
- `err_code` output 2: 1 = overlap, 2 = short-field saturate, 3 = long-field saturate. Holds its value until the next `err`.

## Operation
- Reset values: all outputs 0, state IDLE, counter 0.
- Per-cycle sample is (s,g) = (`sync`,`gate`).
- One internal LONG_W counter `cnt` runs per phase. Every phase entry loads `cnt`=1.
- IDLE
  - (1,0) → SYNC.
  - Any other sample: stay in IDLE.
- SYNC
  - (1,0): `cnt`++.
  - (0,0): capture tsync=`cnt`, go to GDEL.
  - (0,1): capture tsync=`cnt` and tgdel=0, go to GATE.
  - (1,1): err with code 1, go to IDLE.
- GDEL
  - (0,0): `cnt`++.
  - (0,1): capture tgdel=`cnt`, go to GATE.
  - s=1: err with code 1, go to IDLE.
- GATE
  - (0,1): `cnt`++.
  - (0,0): capture tgate=`cnt`, go to LEN.
  - s=1: err with code 1, go to IDLE.
- LEN
  - (0,0) with `done`=0: `cnt`++.
  - (1,0): frame complete with tlen=`cnt`, pulse `valid`, go to SYNC with `cnt`=1. This makes back-to-back frames lossless.
  - `done`=1: frame complete with tlen=`cnt`, pulse `valid`, go to IDLE.
  - g=1: err with code 1, go to IDLE.
  - If `done` and (1,0) occur in the same cycle, `done` wins (go to IDLE).
- Captured values are staged internally. The output registers tsync/tgdel/tgate/tlen load only together with `valid`. Outputs therefore always describe one complete frame.
- Short-field saturation:
  - Applies in SYNC and GDEL when `cnt` would exceed 2^SHORT_W−1.
  - Response: err with code 2, go to IDLE.
- Long-field saturation:
  - Applies in GATE and LEN when `cnt` would exceed 2^LONG_W−1.
  - Response: err with code 3, go to IDLE.
- `ena`=0 in any state: go to IDLE, clear `cnt`, discard staged values. No `valid`, no `err`. Output registers keep their values.
- `valid` and `err` are never asserted in the same cycle.

## Timing
- Latency: `valid`/`err` rise on the clock edge that samples the terminating (s,g) or `done`, i.e. they are registered with 1-cycle latency. Measurements are updated on that same edge.
- Measurement values are exact cycle counts. A Sync pulse high for N sampled cycles yields tsync=N.
- Throughput: one frame per frame. No dead cycle between consecutive frames.
- Asynchronous reset mid-frame: everything returns to the reset values immediately. The frame in progress is lost.

## Structure
- Shared package `sync_gate_pkg` holds:
  - the state enum (IDLE, SYNC, GDEL, GATE, LEN);
  - the `err_code` localparams;
  - the default widths SHORT_W=8 and LONG_W=16. The generator reuses these widths.
- One sub-module, `phase_counter`:
  - loadable counter, LONG_W wide;
  - `limit` input, so one instance serves both the short and the long fields;
  - `sat` output, asserted when the next increment would exceed `limit`.
- The FSM, the staging registers and the output registers stay in `sync_gate_meter`.

## Test plan
- Frame Tsync=3, Tgdel=2, Tgate=5, Tlen=4, ended by `done` → one `valid`; tsync=3, tgdel=2, tgate=5, tlen=4; state returns to IDLE.
- Gate rises the cycle after Sync falls (Tgdel=0), Tsync=1, Tgate=1, Tlen=1 → `valid` with tsync=1, tgdel=0, tgate=1, tlen=1.
- Two back-to-back frames (3,2,5,4) then (7,1,10,20) with no gap → two `valid` pulses, each carrying its own frame's values, no lost cycle.
- Gate asserted while Sync is high → `err` with err_code=1; outputs unchanged from the previous frame; the next clean frame measures correctly.
- Sync held high for 300 cycles → `err` with err_code=2 on the cycle that would reach 256; no `valid`.
- `ena` dropped in GATE, and separately `rst_n` pulsed in LEN → no `valid`/`err` for the aborted frame; after `rst_n`, all outputs are 0; a subsequent frame measures correctly.
